// File: rtl/ticket_sender.sv
// ticket_sender: initiator end of the lottery digit-entry interface.
// Builds a 5-digit BCD ticket (LFSR draw or manual), strobes the digits out
// over num/insert, pulses finish, waits for the game and captures the result.
module ticket_sender #(
    parameter int GAP         = 1,
    parameter int RESULT_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        manual,
    input  logic [19:0] tick,
    input  logic        seed_load,
    input  logic [15:0] seed,
    input  logic        win,
    input  logic [1:0]  prize,
    output logic [3:0]  num,
    output logic        insert,
    output logic        finish,
    output logic        busy,
    output logic        done,
    output logic [19:0] ticket_out,
    output logic        res_win,
    output logic [1:0]  res_prize,
    output logic [7:0]  win_count
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_GEN  = 3'd1;
    localparam logic [2:0] S_SEND = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;
    localparam logic [2:0] S_WAIT = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam logic [15:0] LFSR_INIT = 16'hACE1;

    // Terminal counts for the gap and result-wait counters (counting from 0).
    localparam int GAP_LAST_I  = (GAP > 0) ? GAP - 1 : 0;
    localparam int WAIT_LAST_I = (RESULT_WAIT > 0) ? RESULT_WAIT - 1 : 0;
    localparam logic [15:0] GAP_LAST  = 16'(GAP_LAST_I);
    localparam logic [15:0] WAIT_LAST = 16'(WAIT_LAST_I);

    logic [2:0]  state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  num_q, num_d;
    logic        insert_q, insert_d;
    logic        finish_q, finish_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [19:0] ticket_q, ticket_d;
    logic        res_win_q, res_win_d;
    logic [1:0]  res_prize_q, res_prize_d;
    logic [7:0]  win_count_q, win_count_d;

    logic [3:0]  cand;
    logic [15:0] lfsr_step;
    logic [2:0]  next_idx;
    logic        adv;

    function automatic logic [3:0] digit_at(input logic [19:0] t, input logic [2:0] i);
        case (i)
            3'd0:    digit_at = t[3:0];
            3'd1:    digit_at = t[7:4];
            3'd2:    digit_at = t[11:8];
            3'd3:    digit_at = t[15:12];
            default: digit_at = t[19:16];
        endcase
    endfunction

    // Next-state and registered-output logic; outputs are computed for the
    // state being entered so they line up with it cycle for cycle.
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        num_d       = num_q;
        insert_d    = 1'b0;
        finish_d    = 1'b0;
        done_d      = 1'b0;
        ticket_d    = ticket_q;
        res_win_d   = res_win_q;
        res_prize_d = res_prize_q;
        win_count_d = win_count_q;
        cand        = lfsr_q[3:0];
        lfsr_step   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        next_idx    = idx_q + 3'd1;
        adv         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (seed_load) begin
                    lfsr_d = (seed == 16'd0) ? LFSR_INIT : seed;
                end
                if (start) begin
                    idx_d = 3'd0;
                    if (manual) begin
                        ticket_d = tick;
                        num_d    = tick[3:0];
                        insert_d = 1'b1;
                        state_d  = S_SEND;
                    end else begin
                        ticket_d = 20'd0;
                        state_d  = S_GEN;
                    end
                end
            end
            S_GEN: begin
                lfsr_d = lfsr_step;
                if (cand <= 4'd9) begin
                    ticket_d[{idx_q, 2'b00} +: 4] = cand;
                    if (idx_q == 3'd4) begin
                        idx_d    = 3'd0;
                        num_d    = ticket_q[3:0];
                        insert_d = 1'b1;
                        state_d  = S_SEND;
                    end else begin
                        idx_d = next_idx;
                    end
                end
            end
            S_SEND: begin
                if (GAP > 0) begin
                    cnt_d   = 16'd0;
                    state_d = S_GAP;
                end else begin
                    adv = 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    adv = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_FIN: begin
                cnt_d   = 16'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    done_d      = 1'b1;
                    res_win_d   = win;
                    res_prize_d = prize;
                    if (win && (win_count_q != 8'hFF)) begin
                        win_count_d = win_count_q + 8'd1;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Move on to the next digit, or to the finish strobe after digit 4.
        if (adv) begin
            if (idx_q == 3'd4) begin
                finish_d = 1'b1;
                state_d  = S_FIN;
            end else begin
                idx_d    = next_idx;
                num_d    = digit_at(ticket_q, next_idx);
                insert_d = 1'b1;
                state_d  = S_SEND;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    // State, LFSR and output registers; reset aborts any transaction at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            lfsr_q      <= LFSR_INIT;
            idx_q       <= 3'd0;
            cnt_q       <= 16'd0;
            num_q       <= 4'd0;
            insert_q    <= 1'b0;
            finish_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ticket_q    <= 20'd0;
            res_win_q   <= 1'b0;
            res_prize_q <= 2'd0;
            win_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            num_q       <= num_d;
            insert_q    <= insert_d;
            finish_q    <= finish_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ticket_q    <= ticket_d;
            res_win_q   <= res_win_d;
            res_prize_q <= res_prize_d;
            win_count_q <= win_count_d;
        end
    end

    assign num        = num_q;
    assign insert     = insert_q;
    assign finish     = finish_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ticket_out = ticket_q;
    assign res_win    = res_win_q;
    assign res_prize  = res_prize_q;
    assign win_count  = win_count_q;

endmodule

// File: tb/tb_ticket_sender.sv
// Bench for ticket_sender: vector table, hand-written corner sequences and
// randomized transactions against a ticket/win-count reference model.
module tb_ticket_sender;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        manual = 1'b0;
    logic [19:0] tick = '0;
    logic        seed_load = 1'b0;
    logic [15:0] seed = '0;
    logic        win = 1'b0;
    logic [1:0]  prize = '0;
    logic [3:0]  num;
    logic        insert;
    logic        finish;
    logic        busy;
    logic        done;
    logic [19:0] ticket_out;
    logic        res_win;
    logic [1:0]  res_prize;
    logic [7:0]  win_count;

    ticket_sender #(.GAP(1), .RESULT_WAIT(4)) dut (
        .clk(clk), .reset(reset), .start(start), .manual(manual), .tick(tick),
        .seed_load(seed_load), .seed(seed), .win(win), .prize(prize),
        .num(num), .insert(insert), .finish(finish), .busy(busy), .done(done),
        .ticket_out(ticket_out), .res_win(res_win), .res_prize(res_prize),
        .win_count(win_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [15:0] m_lfsr;
    int m_wc;

    typedef struct {
        bit          man;
        logic [19:0] tk;
        bit          sl;
        logic [15:0] sd;
        bit          wv;
        logic [1:0]  pv;
        logic [19:0] exp_t;
        int          exp_g;
    } vec_t;

    vec_t tab[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {25'd0, num, insert, finish, busy, done, ticket_out, res_win, res_prize, win_count};
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    // Draw a ticket from the model LFSR: keep candidates 0..9, count all candidates.
    task automatic model_draw(output logic [19:0] t, output int g);
        logic [3:0] c;
        int n;
        t = '0;
        g = 0;
        n = 0;
        while (n < 5 && g < 1000) begin
            c = m_lfsr[3:0];
            m_lfsr = lfsr_next(m_lfsr);
            g++;
            if (c <= 4'd9) begin
                t[n*4 +: 4] = c;
                n++;
            end
        end
    endtask

    task automatic run_txn(input string tag, input bit man, input logic [19:0] tk,
                           input bit sl, input logic [15:0] sd, input bit wv,
                           input logic [1:0] pv, input logic [19:0] exp_t,
                           input int exp_g, input int poke);
        logic [3:0] got[5];
        int ins_n, fin_n, done_n, fin_cyc, done_cyc, first_ins, fall, viol, exp_wc;
        bit prev_ins;
        logic [19:0] t_at_done;
        logic rw_at;
        logic [1:0] rp_at;
        logic [7:0] wc_at;
        got = '{default: 4'hx};
        ins_n = 0; fin_n = 0; done_n = 0; fin_cyc = -1; done_cyc = -1;
        first_ins = -1; fall = -1; viol = 0; prev_ins = 0;
        t_at_done = 'x; rw_at = 1'bx; rp_at = 'x; wc_at = 'x;
        exp_wc = wv ? ((m_wc < 255) ? m_wc + 1 : 255) : m_wc;
        m_wc = exp_wc;

        @(negedge clk);
        start = 1'b1; manual = man; tick = tk; seed_load = sl; seed = sd;
        win = 1'b0; prize = 2'b00;
        @(posedge clk);
        #1;
        start = 1'b0;
        seed_load = 1'b0;
        chk({tag, " busy_after_start"}, 64'(busy), 64'd1);

        for (int cyc = 0; cyc < 400 && fall < 0; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk);
                #1;
            end
            start = (cyc == poke);
            if (insert && finish) viol++;
            if (insert && prev_ins) viol++;
            if (insert) begin
                if (ins_n < 5) got[ins_n] = num;
                if (ins_n == 0) first_ins = cyc;
                ins_n++;
            end
            prev_ins = insert;
            if (finish) begin
                fin_n++;
                fin_cyc = cyc;
            end
            if (fin_cyc >= 0 && cyc == fin_cyc + 3) begin
                win = wv;
                prize = pv;
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
                t_at_done = ticket_out;
                rw_at = res_win;
                rp_at = res_prize;
                wc_at = win_count;
            end
            if (!busy) fall = cyc;
        end
        start = 1'b0;

        chk({tag, " busy_fall_cycle"}, 64'(fall), 64'(16 + exp_g));
        chk({tag, " insert_count"}, 64'(ins_n), 64'd5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("%s num%0d", tag, i), 64'(got[i]), 64'(exp_t[i*4 +: 4]));
        chk({tag, " first_insert_cycle"}, 64'(first_ins), 64'(exp_g));
        chk({tag, " finish_count"}, 64'(fin_n), 64'd1);
        chk({tag, " finish_cycle"}, 64'(fin_cyc), 64'(10 + exp_g));
        chk({tag, " done_count"}, 64'(done_n), 64'd1);
        chk({tag, " done_cycle"}, 64'(done_cyc), 64'(15 + exp_g));
        chk({tag, " strobe_violations"}, 64'(viol), 64'd0);
        chk({tag, " ticket_at_done"}, 64'(t_at_done), 64'(exp_t));
        chk({tag, " res_win"}, 64'(rw_at), 64'(wv));
        chk({tag, " res_prize"}, 64'(rp_at), 64'(pv));
        chk({tag, " win_count"}, 64'(wc_at), 64'(exp_wc));
        chk({tag, " ticket_held"}, 64'(ticket_out), 64'(exp_t));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [19:0] et;
        int eg;
        bit man, sl, wv;
        logic [19:0] tk;
        logic [15:0] sd;
        logic [1:0] pv;
        int fin_seen;

        tab[0] = '{1'b0, 20'h00000, 1'b0, 16'h0000, 1'b0, 2'b00, 20'h29731, 8};
        tab[1] = '{1'b1, 20'h76905, 1'b0, 16'h0000, 1'b1, 2'b01, 20'h76905, 0};
        tab[2] = '{1'b0, 20'h00000, 1'b1, 16'h0000, 1'b0, 2'b10, 20'h29731, 8};
        tab[3] = '{1'b1, 20'hFA0B3, 1'b1, 16'h1234, 1'b0, 2'b11, 20'hFA0B3, 0};
        tab[4] = '{1'b0, 20'h00000, 1'b1, 16'h0000, 1'b1, 2'b11, 20'h29731, 8};
        tab[5] = '{1'b1, 20'h99999, 1'b0, 16'h0000, 1'b1, 2'b10, 20'h99999, 0};

        // Reset state
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", all_outs(), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        m_lfsr = 16'hACE1;
        m_wc = 0;

        // Vector table
        for (int i = 0; i < 6; i++) begin
            if (tab[i].sl) m_lfsr = (tab[i].sd == 16'd0) ? 16'hACE1 : tab[i].sd;
            if (!tab[i].man) model_draw(et, eg);
            run_txn($sformatf("vec%0d", i), tab[i].man, tab[i].tk, tab[i].sl, tab[i].sd,
                    tab[i].wv, tab[i].pv, tab[i].exp_t, tab[i].exp_g, -1);
        end

        // start pulsed during SEND is ignored
        run_txn("poke", 1'b1, 20'h31415, 1'b0, 16'h0, 1'b1, 2'b10, 20'h31415, 0, 2);

        // Randomized transactions against the model
        for (int r = 0; r < 24; r++) begin
            man = 1'($urandom_range(0, 1));
            tk = 20'($urandom);
            sl = ($urandom_range(0, 3) == 0);
            sd = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            wv = 1'($urandom_range(0, 1));
            pv = 2'($urandom_range(0, 3));
            if (sl) m_lfsr = (sd == 16'd0) ? 16'hACE1 : sd;
            if (man) begin
                et = tk;
                eg = 0;
            end else begin
                model_draw(et, eg);
            end
            run_txn($sformatf("rnd%0d", r), man, tk, sl, sd, wv, pv, et, eg, -1);
        end

        // Reset during the gap after digit 2
        @(negedge clk);
        start = 1'b1; manual = 1'b1; tick = 20'h12345; seed_load = 1'b0;
        win = 1'b0; prize = 2'b00;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("midreset_in_gap", 64'({insert, busy, num}), 64'({1'b0, 1'b1, 4'h3}));
        reset = 1'b0;
        #1;
        chk("midreset_outputs", all_outs(), 64'd0);
        fin_seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (finish || busy) fin_seen++;
        end
        chk("midreset_no_finish", 64'(fin_seen), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        m_lfsr = 16'hACE1;
        m_wc = 0;
        model_draw(et, eg);
        run_txn("after_reset", 1'b0, 20'h0, 1'b0, 16'h0, 1'b0, 2'b00, et, eg, -1);

        // win_count saturation over 256 winning transactions
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_lfsr = 16'hACE1;
        m_wc = 0;
        for (int n = 1; n <= 256; n++) begin
            tk = 20'($urandom);
            run_txn($sformatf("sat%0d", n), 1'b1, tk, 1'b0, 16'h0, 1'b1, 2'b01, tk, 0, -1);
            if (n == 255) chk("win_count_at_255", 64'(win_count), 64'd255);
            if (n == 256) chk("win_count_at_256", 64'(win_count), 64'd255);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
